buffer_sched: RTL and testbench
===============================

BUFFER_SCHED -- requirements
Module: buffer_sched

Interface
REQ-001 Parameter: DATA_W, 4, width of one buffer word.
REQ-002 Parameter: ADDR_W, 4, buffer address width; depth = 2**ADDR_W (16).
REQ-003 Parameter: DRAIN_CYCLES, 64, cycles the buffer needs to shift out its full contents serially.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 Ports SHALL be:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_a  input  1  requester A has a word pending.
- data_a  input  DATA_W  requester A word.
- gnt_a  output  1  one-cycle pulse; A's word written.
- req_b  input  1  requester B has a word pending.
- data_b  input  DATA_W  requester B word.
- gnt_b  output  1  one-cycle pulse; B's word written.
- flush  input  1  drain a partially filled buffer.
- buf_ena  output  1  write enable to the buffer.
- buf_addr  output  ADDR_W  buffer write address.
- buf_data  output  DATA_W  buffer write data.
- fill_cnt  output  ADDR_W+1  words written in the current frame, 0..16.
- busy  output  1  high while draining.
- done  output  1  one-cycle pulse at the end of a drain.

Function
REQ-006 All outputs SHALL be registered. There is no combinational path from input to output.
REQ-007 States SHALL be IDLE, FILL, DRAIN and DONE. Reset state is IDLE.
REQ-008 Requester handshake: a requester holds req_x and data_x stable until it samples gnt_x=1. It may deassert req_x on the cycle after the grant.
REQ-009 In IDLE or FILL, when at least one req is high at a rising edge, the block SHALL grant exactly one requester at that edge. That edge sets gnt_x=1, buf_ena=1, buf_addr=wr_ptr and buf_data=data_x, giving one cycle of latency.
REQ-010 Arbitration SHALL be round-robin. If both requesters are high, the one not granted last wins. After reset, A has priority.
REQ-011 The block SHALL NOT grant on the cycle after a grant. Each granted word occupies two cycles, so a requester dropping req after its grant never gets a double grant.
REQ-012 On each grant, wr_ptr SHALL increment modulo 16 and fill_cnt SHALL increment.
REQ-013 The first grant in IDLE moves the FSM to FILL.
REQ-014 When fill_cnt reaches 16, the FSM SHALL enter DRAIN on the next edge and wr_ptr wraps to 0.
REQ-015 flush=1 in FILL SHALL enter DRAIN on the next edge.
- flush in IDLE (fill_cnt=0) is ignored.
- flush in DRAIN or DONE is ignored.
REQ-016 If flush and a grant coincide in FILL, the word is written and the FSM then enters DRAIN.
REQ-017 In DRAIN:
- busy=1 and buf_ena=0.
- No grants are issued; requests stay pending.
- An internal counter runs for exactly DRAIN_CYCLES cycles, after which the FSM moves to DONE.
REQ-018 DONE SHALL last one cycle with done=1. It clears fill_cnt and wr_ptr, then returns to IDLE. The first new grant can come on the following edge.
REQ-019 buf_ena, gnt_a and gnt_b SHALL be 0 in every cycle without a grant. buf_addr and buf_data hold their last values.
REQ-020 gnt_a and gnt_b SHALL never be high in the same cycle.

Reset
REQ-021 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE.
- gnt_a=gnt_b=buf_ena=busy=done=0.
- buf_addr=0, buf_data=0, fill_cnt=0.
- wr_ptr=0 and the drain counter=0.
- Round-robin pointer set so that A has priority.
REQ-022 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the frame without any further buffer write.
REQ-023 After rst_n deasserts, the first edge can issue a grant.

Verification
REQ-024 Single requester: req_a=1 holding 16 distinct words.
- Required: 16 gnt_a pulses, each two cycles apart.
- buf_addr runs 0..15 with the matching buf_data.
- busy=1 for exactly 64 cycles, then done pulses once and fill_cnt returns to 0.
REQ-025 Contention: req_a=req_b=1 continuously from reset.
- Required grant order: A, B, A, B...
- After 16 grants: A owns even addresses, B owns odd addresses.
REQ-026 Partial flush: write 3 words, then pulse flush.
- Required: DRAIN entered the next edge with fill_cnt=3, busy for 64 cycles, then done.
- A flush pulsed afterwards in IDLE does nothing.
REQ-027 Flush coinciding with a grant at fill_cnt=5.
- Required: the word is written at address 5, fill_cnt=6, then DRAIN.
REQ-028 Requests during DRAIN: req_b held high throughout DRAIN.
- Required: no gnt_b during busy.
- gnt_b comes on the edge after DONE's return to IDLE, with buf_addr=0.
REQ-029 Reset mid-drain: rst_n=0 at drain cycle 30.
- Required: all outputs go to 0 asynchronously.
- After release, a new frame starts at address 0.

Source files
------------

// File: rtl/buffer_sched.sv
// Two-requester round-robin writer into a 2**ADDR_W word buffer. Frames close
// when the buffer fills or on flush, then drain for a fixed number of cycles.
module buffer_sched #(
    parameter int DATA_W       = 4,
    parameter int ADDR_W       = 4,
    parameter int DRAIN_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              gnt_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              gnt_b,
    input  logic              flush,
    output logic              buf_ena,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_data,
    output logic [ADDR_W:0]   fill_cnt,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     fill_q, fill_d;
    logic [CNT_W-1:0]    dcnt_q, dcnt_d;
    logic                last_b_q, last_b_d;
    logic                gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
    logic                ena_q, ena_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic can_grant, pick_a, grant_a, grant_b;

    // ena_q marks the cycle right after a grant: every word takes two cycles,
    // so a requester dropping req after its grant is never granted twice.
    assign can_grant = (state_q == S_IDLE || state_q == S_FILL) && !ena_q &&
                       (fill_q != (ADDR_W+1)'(DEPTH));
    assign pick_a    = req_a && (!req_b || last_b_q);
    assign grant_a   = can_grant && pick_a;
    assign grant_b   = can_grant && req_b && !pick_a;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        dcnt_d   = dcnt_q;
        last_b_d = last_b_q;
        gnt_a_d  = 1'b0;
        gnt_b_d  = 1'b0;
        ena_d    = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        if (grant_a || grant_b) begin
            gnt_a_d  = grant_a;
            gnt_b_d  = grant_b;
            ena_d    = 1'b1;
            addr_d   = wr_ptr_q;
            data_d   = grant_a ? data_a : data_b;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
            last_b_d = grant_b;
        end

        case (state_q)
            S_IDLE: begin
                if (grant_a || grant_b) state_d = S_FILL;
            end
            S_FILL: begin
                // A grant coinciding with flush still lands before the drain.
                if (flush || fill_q == (ADDR_W+1)'(DEPTH)) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = S_DONE;
                else                                     dcnt_d  = dcnt_q + 1'b1;
            end
            S_DONE: begin
                state_d  = S_IDLE;
                wr_ptr_d = '0;
                fill_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            dcnt_q   <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            ena_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            dcnt_q   <= dcnt_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= gnt_a_d;
            gnt_b_q  <= gnt_b_d;
            ena_q    <= ena_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign gnt_a    = gnt_a_q;
    assign gnt_b    = gnt_b_q;
    assign buf_ena  = ena_q;
    assign buf_addr = addr_q;
    assign buf_data = data_q;
    assign fill_cnt = fill_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_buffer_sched.sv
// Bench for buffer_sched: queue-driven requesters, a grant/drain event log and
// a frame-level model (round-robin order, sequential addresses, 64-cycle drains).
module tb_buffer_sched;

    localparam int DW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0, flush = 1'b0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic          gnt_a, gnt_b, buf_ena, busy, done;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic [AW:0]   fill_cnt;

    buffer_sched #(.DATA_W(DW), .ADDR_W(AW), .DRAIN_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .data_a(data_a), .gnt_a(gnt_a),
        .req_b(req_b), .data_b(data_b), .gnt_b(gnt_b),
        .flush(flush), .buf_ena(buf_ena), .buf_addr(buf_addr), .buf_data(buf_data),
        .fill_cnt(fill_cnt), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;

    // requester word queues; front word is what the requester presents
    logic [DW-1:0] qa[$], qb[$];

    // event log
    int g_cyc[$], g_who[$], g_addr[$], g_eaddr[$], g_data[$], g_edata[$], g_fill[$];
    bit g_ra[$], g_rb[$], g_pbusy[$], g_dual[$];
    int busy_runs[$], drain_fill[$], done_cyc[$];
    int cyc_n, busy_len, m_ptr;
    bit p_busy, d_ra, d_rb;

    task automatic clear_model();
        g_cyc.delete(); g_who.delete(); g_addr.delete(); g_eaddr.delete();
        g_data.delete(); g_edata.delete(); g_fill.delete();
        g_ra.delete(); g_rb.delete(); g_pbusy.delete(); g_dual.delete();
        busy_runs.delete(); drain_fill.delete(); done_cyc.delete();
        cyc_n = 0; busy_len = 0; m_ptr = 0; p_busy = 0;
    endtask

    task automatic drive();
        req_a = (qa.size() > 0);
        req_b = (qb.size() > 0);
        if (req_a) data_a = qa[0];
        if (req_b) data_b = qb[0];
        d_ra = req_a;
        d_rb = req_b;
    endtask

    // one clock: observe outputs at the falling edge, log events, redrive requesters
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (gnt_a || gnt_b) begin
            g_cyc.push_back(cyc_n);
            g_who.push_back(gnt_a ? 0 : 1);
            g_dual.push_back(gnt_a && gnt_b);
            g_addr.push_back(int'(buf_addr));
            g_data.push_back(int'(buf_data));
            g_fill.push_back(int'(fill_cnt));
            g_eaddr.push_back(m_ptr);
            m_ptr = (m_ptr + 1) % 16;
            g_ra.push_back(d_ra);
            g_rb.push_back(d_rb);
            g_pbusy.push_back(p_busy);
            if (gnt_a) g_edata.push_back(qa.size() > 0 ? int'(qa.pop_front()) : -1);
            else       g_edata.push_back(qb.size() > 0 ? int'(qb.pop_front()) : -1);
        end
        if (busy) begin
            if (busy_len == 0) drain_fill.push_back(int'(fill_cnt));
            busy_len++;
        end else if (busy_len > 0) begin
            busy_runs.push_back(busy_len);
            busy_len = 0;
        end
        if (done) begin
            done_cyc.push_back(cyc_n);
            m_ptr = 0;
        end
        p_busy = busy;
        drive();
    endtask

    task automatic do_reset();
        qa.delete(); qb.delete();
        flush = 1'b0;
        #2 rst_n = 1'b0;
        drive();
        @(negedge clk);
        @(negedge clk);
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        qa.push_back(4'hF); qa.push_back(4'hE); qa.push_back(4'hD);
        drive();
        for (int i = 0; i < 6; i++) cyc();
        #2 rst_n = 1'b0;
        #1;
        total++; if (gnt_a !== 1'b0)    $display("FAIL rst_gnt_a got %b exp 0", gnt_a);    else passed++;
        total++; if (gnt_b !== 1'b0)    $display("FAIL rst_gnt_b got %b exp 0", gnt_b);    else passed++;
        total++; if (buf_ena !== 1'b0)  $display("FAIL rst_buf_ena got %b exp 0", buf_ena); else passed++;
        total++; if (busy !== 1'b0)     $display("FAIL rst_busy got %b exp 0", busy);      else passed++;
        total++; if (done !== 1'b0)     $display("FAIL rst_done got %b exp 0", done);      else passed++;
        total++; if (buf_addr !== '0)   $display("FAIL rst_buf_addr got %0d exp 0", buf_addr); else passed++;
        total++; if (buf_data !== '0)   $display("FAIL rst_buf_data got %0d exp 0", buf_data); else passed++;
        total++; if (fill_cnt !== '0)   $display("FAIL rst_fill_cnt got %0d exp 0", fill_cnt); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] base;
        do_reset();
        base = DW'($urandom);
        for (int i = 0; i < 16; i++) qa.push_back(base + DW'(i));
        drive();
        for (int i = 0; i < 400 && done_cyc.size() == 0; i++) cyc();
        cyc(); cyc();
        total++; if (done_cyc.size() != 1) $display("FAIL single_done_pulses got %0d exp 1", done_cyc.size()); else passed++;
        total++; if (g_who.size() != 16) $display("FAIL single_grants got %0d exp 16", g_who.size()); else passed++;
        if (g_cyc.size() > 0) begin
            total++; if (g_cyc[0] != 1) $display("FAIL single_first_latency got %0d exp 1", g_cyc[0]); else passed++;
        end
        for (int i = 0; i < g_who.size(); i++) begin
            total++; if (g_who[i] != 0) $display("FAIL single_who[%0d] got %0d exp 0", i, g_who[i]); else passed++;
            total++; if (g_addr[i] != i) $display("FAIL single_addr[%0d] got %0d exp %0d", i, g_addr[i], i); else passed++;
            total++; if (g_data[i] != g_edata[i]) $display("FAIL single_data[%0d] got %0d exp %0d", i, g_data[i], g_edata[i]); else passed++;
            if (i > 0) begin
                total++; if (g_cyc[i] - g_cyc[i-1] != 2) $display("FAIL single_spacing[%0d] got %0d exp 2", i, g_cyc[i] - g_cyc[i-1]); else passed++;
            end
        end
        total++; if (busy_runs.size() != 1 || busy_runs[0] != 64)
            $display("FAIL single_busy_len got %0d exp 64", busy_runs.size() > 0 ? busy_runs[0] : 0); else passed++;
        total++; if (drain_fill.size() != 1 || drain_fill[0] != 16)
            $display("FAIL single_drain_fill got %0d exp 16", drain_fill.size() > 0 ? drain_fill[0] : -1); else passed++;
        total++; if (fill_cnt !== '0) $display("FAIL single_fill_after got %0d exp 0", fill_cnt); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            qa.push_back(DW'($urandom));
            qb.push_back(DW'($urandom));
        end
        drive();
        for (int i = 0; i < 100 && g_who.size() < 16; i++) cyc();
        total++; if (g_who.size() != 16) $display("FAIL cont_grants got %0d exp 16", g_who.size()); else passed++;
        for (int i = 0; i < g_who.size(); i++) begin
            total++; if (g_who[i] != i % 2) $display("FAIL cont_order[%0d] got %0d exp %0d", i, g_who[i], i % 2); else passed++;
            total++; if (g_addr[i] % 2 != g_who[i]) $display("FAIL cont_parity[%0d] addr %0d who %0d", i, g_addr[i], g_who[i]); else passed++;
            total++; if (g_data[i] != g_edata[i]) $display("FAIL cont_data[%0d] got %0d exp %0d", i, g_data[i], g_edata[i]); else passed++;
            total++; if (g_dual[i]) $display("FAIL cont_dual[%0d] got 1 exp 0", i); else passed++;
        end
        for (int i = 0; i < 200 && done_cyc.size() == 0; i++) cyc();
    endtask

    task automatic test_flush_partial();
        do_reset();
        for (int i = 0; i < 3; i++) qa.push_back(DW'($urandom));
        drive();
        for (int i = 0; i < 50 && g_who.size() < 3; i++) cyc();
        total++; if (g_who.size() != 3) $display("FAIL flush3_grants got %0d exp 3", g_who.size()); else passed++;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL flush3_busy got %b exp 1", busy); else passed++;
        total++; if (fill_cnt !== 5'd3) $display("FAIL flush3_fill got %0d exp 3", fill_cnt); else passed++;
        for (int i = 0; i < 100 && done_cyc.size() == 0; i++) cyc();
        total++; if (busy_runs.size() != 1 || busy_runs[0] != 64)
            $display("FAIL flush3_busy_len got %0d exp 64", busy_runs.size() > 0 ? busy_runs[0] : 0); else passed++;
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        total++; if (busy_runs.size() != 1 || busy_len != 0) $display("FAIL flush_idle_busy got %0d exp 0", busy_len); else passed++;
        total++; if (fill_cnt !== '0) $display("FAIL flush_idle_fill got %0d exp 0", fill_cnt); else passed++;
    endtask

    task automatic test_flush_grant();
        do_reset();
        for (int i = 0; i < 6; i++) qa.push_back(DW'($urandom));
        drive();
        for (int i = 0; i < 50 && g_who.size() < 5; i++) cyc();
        cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        total++; if (gnt_a !== 1'b1) $display("FAIL fgrant_gnt got %b exp 1", gnt_a); else passed++;
        total++; if (buf_addr !== 4'd5) $display("FAIL fgrant_addr got %0d exp 5", buf_addr); else passed++;
        total++; if (fill_cnt !== 5'd6) $display("FAIL fgrant_fill got %0d exp 6", fill_cnt); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL fgrant_busy got %b exp 1", busy); else passed++;
        for (int i = 0; i < 100 && done_cyc.size() == 0; i++) cyc();
        total++; if (done_cyc.size() != 1) $display("FAIL fgrant_done got %0d exp 1", done_cyc.size()); else passed++;
    endtask

    task automatic test_drain_req();
        int bi;
        do_reset();
        for (int i = 0; i < 16; i++) qa.push_back(DW'($urandom));
        drive();
        for (int i = 0; i < 100 && !busy; i++) cyc();
        qb.push_back(DW'($urandom));
        drive();
        for (int i = 0; i < 100 && done_cyc.size() == 0; i++) cyc();
        for (int i = 0; i < 3; i++) cyc();
        bi = -1;
        for (int i = 0; i < g_who.size(); i++) begin
            if (g_who[i] == 1 && bi < 0) bi = i;
            total++; if (g_pbusy[i]) $display("FAIL drain_grant_in_busy[%0d] got 1 exp 0", i); else passed++;
        end
        total++; if (bi < 0 || done_cyc.size() != 1) $display("FAIL drain_b_granted got %0d exp 16", bi); else passed++;
        if (bi >= 0 && done_cyc.size() == 1) begin
            total++; if (g_cyc[bi] != done_cyc[0] + 2) $display("FAIL drain_b_timing got %0d exp %0d", g_cyc[bi], done_cyc[0] + 2); else passed++;
            total++; if (g_addr[bi] != 0) $display("FAIL drain_b_addr got %0d exp 0", g_addr[bi]); else passed++;
        end
        for (int i = 0; i < 100 && done_cyc.size() < 2; i++) begin flush = 1'b1; cyc(); end
        flush = 1'b0;
    endtask

    task automatic test_reset_drain();
        logic [DW-1:0] w;
        do_reset();
        for (int i = 0; i < 16; i++) qa.push_back(DW'($urandom));
        drive();
        for (int i = 0; i < 200 && busy_len < 30; i++) cyc();
        total++; if (busy_len != 30) $display("FAIL rdrain_reach got %0d exp 30", busy_len); else passed++;
        w = DW'($urandom);
        qb.push_back(w);
        drive();
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0)   $display("FAIL rdrain_busy got %b exp 0", busy); else passed++;
        total++; if (fill_cnt !== '0) $display("FAIL rdrain_fill got %0d exp 0", fill_cnt); else passed++;
        total++; if (buf_addr !== '0) $display("FAIL rdrain_addr got %0d exp 0", buf_addr); else passed++;
        total++; if (buf_data !== '0) $display("FAIL rdrain_data got %0d exp 0", buf_data); else passed++;
        @(posedge clk); #1;
        total++; if (buf_ena !== 1'b0 || gnt_b !== 1'b0) $display("FAIL rdrain_hold_write got %b exp 0", buf_ena | gnt_b); else passed++;
        @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        cyc();
        total++; if (g_who.size() != 1) $display("FAIL rdrain_regrant got %0d exp 1", g_who.size()); else passed++;
        if (g_who.size() == 1) begin
            total++; if (g_addr[0] != 0) $display("FAIL rdrain_new_addr got %0d exp 0", g_addr[0]); else passed++;
            total++; if (g_data[0] != int'(w)) $display("FAIL rdrain_new_data got %0d exp %0d", g_data[0], w); else passed++;
        end
    endtask

    task automatic test_random();
        int last, exp_who;
        do_reset();
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0 && qa.size() < 4) qa.push_back(DW'($urandom));
            if ($urandom_range(0, 2) == 0 && qb.size() < 4) qb.push_back(DW'($urandom));
            drive();
            flush = ($urandom_range(0, 29) == 0);
            cyc();
        end
        flush = 1'b0;
        total++; if (g_who.size() < 20) $display("FAIL rnd_activity got %0d exp >=20", g_who.size()); else passed++;
        last = 1;
        for (int i = 0; i < g_who.size(); i++) begin
            if (g_ra[i] && g_rb[i]) exp_who = 1 - last;
            else                    exp_who = g_ra[i] ? 0 : 1;
            total++; if (g_who[i] != exp_who) $display("FAIL rnd_who[%0d] got %0d exp %0d", i, g_who[i], exp_who); else passed++;
            total++; if (g_addr[i] != g_eaddr[i]) $display("FAIL rnd_addr[%0d] got %0d exp %0d", i, g_addr[i], g_eaddr[i]); else passed++;
            total++; if (g_data[i] != g_edata[i]) $display("FAIL rnd_data[%0d] got %0d exp %0d", i, g_data[i], g_edata[i]); else passed++;
            total++; if (g_fill[i] != g_eaddr[i] + 1) $display("FAIL rnd_fill[%0d] got %0d exp %0d", i, g_fill[i], g_eaddr[i] + 1); else passed++;
            total++; if (g_pbusy[i] || g_dual[i]) $display("FAIL rnd_illegal_grant[%0d] busy %0d dual %0d", i, g_pbusy[i], g_dual[i]); else passed++;
            if (i > 0) begin
                total++; if (g_cyc[i] - g_cyc[i-1] < 2) $display("FAIL rnd_spacing[%0d] got %0d exp >=2", i, g_cyc[i] - g_cyc[i-1]); else passed++;
            end
            last = g_who[i];
        end
        for (int i = 0; i < busy_runs.size(); i++) begin
            total++; if (busy_runs[i] != 64) $display("FAIL rnd_busy_len[%0d] got %0d exp 64", i, busy_runs[i]); else passed++;
        end
        total++; if (done_cyc.size() != busy_runs.size()) $display("FAIL rnd_done_count got %0d exp %0d", done_cyc.size(), busy_runs.size()); else passed++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        test_reset();
        test_single();
        test_contention();
        test_flush_partial();
        test_flush_grant();
        test_drain_req();
        test_reset_drain();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
